// File: rtl/bip_datapath_mul.sv
// Accumulator datapath for the BIP-style core: 8-op ALU, Z/N/C/V status
// register and an iterative unsigned shift-add multiplier with a
// start/busy/done handshake returning a double-width product in ACC/MUL_HI.
module bip_datapath_mul #(
   parameter int OPERAND_WIDTH = 11,
   parameter int DATA_WIDTH    = 16
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
   input  logic [OPERAND_WIDTH-1:0] operand_in,
   input  logic [DATA_WIDTH-1:0]    data_memory_in,
   input  logic [2:0]               alu_op_in,
   input  logic [1:0]               sel_A_in,
   input  logic                     sel_B_in,
   input  logic                     acc_wr_in,
   input  logic                     status_wr_in,
   input  logic                     mul_start_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic [DATA_WIDTH-1:0]    ext_out,
   output logic [OPERAND_WIDTH-1:0] data_memory_address_out,
   output logic [DATA_WIDTH-1:0]    mul_hi_out,
   output logic                     status_Z_out,
   output logic                     status_N_out,
   output logic                     status_C_out,
   output logic                     status_V_out,
   output logic                     busy_out,
   output logic                     done_out
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int W   = DATA_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [W-1:0]   acc_q, hi_q;
   logic           z_q, n_q, c_q, v_q;
   logic [2*W-1:0] mcand_q;
   logic [W-1:0]   mplier_q;
   logic [2*W-1:0] prod_q;
   logic [SHW-1:0] cnt_q;

   logic [W-1:0]   alu_b;
   logic [SHW-1:0] shamt;
   logic [W:0]     sum, diff;
   logic [W-1:0]   alu_r;
   logic           alu_c, alu_v;
   logic [W-1:0]   acc_src;
   logic [2*W-1:0] step_prod;
   logic           last_step;

   assign ext_out                 = W'($signed(operand_in));
   assign data_memory_address_out = operand_in;
   assign data_out                = acc_q;
   assign mul_hi_out              = hi_q;
   assign status_Z_out            = z_q;
   assign status_N_out            = n_q;
   assign status_C_out            = c_q;
   assign status_V_out            = v_q;
   assign busy_out                = (state_q == ST_RUN);
   assign done_out                = (state_q == ST_DONE);

   // ALU: operand B selection, result and carry/overflow
   always_comb begin
      alu_b = sel_B_in ? ext_out : data_memory_in;
      shamt = alu_b[SHW-1:0];
      sum   = {1'b0, acc_q} + {1'b0, alu_b};
      diff  = {1'b0, acc_q} - {1'b0, alu_b};
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_op_in)
         3'b000: begin
            alu_r = sum[W-1:0];
            alu_c = sum[W];
            alu_v = (acc_q[W-1] == alu_b[W-1]) && (alu_r[W-1] != acc_q[W-1]);
         end
         3'b001: begin
            // the extra bit of the widened difference is the unsigned borrow
            alu_r = diff[W-1:0];
            alu_c = diff[W];
            alu_v = (acc_q[W-1] != alu_b[W-1]) && (alu_r[W-1] != acc_q[W-1]);
         end
         3'b010:  alu_r = acc_q & alu_b;
         3'b011:  alu_r = acc_q | alu_b;
         3'b100:  alu_r = acc_q ^ alu_b;
         3'b101:  alu_r = ~acc_q;
         3'b110:  alu_r = acc_q << shamt;
         default: alu_r = acc_q >> shamt;
      endcase
   end

   // ACC write source mux
   always_comb begin
      case (sel_A_in)
         2'b00:   acc_src = data_memory_in;
         2'b01:   acc_src = ext_out;
         2'b10:   acc_src = alu_r;
         default: acc_src = hi_q;
      endcase
   end

   // one shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
      last_step = (cnt_q == SHW'(W - 1));
   end

   // multiplier control FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: state_d = mul_start_in ? ST_RUN : ST_IDLE;
         ST_RUN:           state_d = last_step ? ST_DONE : ST_RUN;
         default:          state_d = ST_IDLE;
      endcase
   end

   // architectural registers and multiplier datapath
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         hi_q     <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_RUN: begin
               prod_q   <= step_prod;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (last_step) begin
                  acc_q <= step_prod[W-1:0];
                  hi_q  <= step_prod[2*W-1:W];
                  z_q   <= (step_prod == '0);
                  n_q   <= step_prod[2*W-1];
                  c_q   <= (step_prod[2*W-1:W] != '0);
                  v_q   <= (step_prod[2*W-1:W] != '0);
               end
            end
            ST_IDLE, ST_DONE: begin
               if (mul_start_in) begin
                  mcand_q  <= {{W{1'b0}}, acc_q};
                  mplier_q <= alu_b;
                  prod_q   <= '0;
                  cnt_q    <= '0;
               end else begin
                  if (acc_wr_in) acc_q <= acc_src;
                  if (status_wr_in) begin
                     z_q <= (alu_r == '0);
                     n_q <= alu_r[W-1];
                     c_q <= alu_c;
                     v_q <= alu_v;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bip_datapath_mul.sv
// Self-checking bench for bip_datapath_mul against an arithmetic reference model.
module tb_bip_datapath_mul;

   localparam int OW = 11;
   localparam int W  = 16;

   logic          clk = 1'b0;
   logic          reset_in;
   logic [OW-1:0] operand_in;
   logic [W-1:0]  data_memory_in;
   logic [2:0]    alu_op_in;
   logic [1:0]    sel_A_in;
   logic          sel_B_in;
   logic          acc_wr_in;
   logic          status_wr_in;
   logic          mul_start_in;
   logic [W-1:0]  data_out;
   logic [W-1:0]  ext_out;
   logic [OW-1:0] data_memory_address_out;
   logic [W-1:0]  mul_hi_out;
   logic          status_Z_out, status_N_out, status_C_out, status_V_out;
   logic          busy_out, done_out;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] m_acc, m_hi;
   logic         m_z, m_n, m_c, m_v;

   logic [2*W+3:0] obs_vec;
   assign obs_vec = {data_out, mul_hi_out, status_Z_out, status_N_out, status_C_out, status_V_out};

   bip_datapath_mul #(.OPERAND_WIDTH(OW), .DATA_WIDTH(W)) dut (
      .clock_in(clk), .reset_in(reset_in), .operand_in(operand_in),
      .data_memory_in(data_memory_in), .alu_op_in(alu_op_in), .sel_A_in(sel_A_in),
      .sel_B_in(sel_B_in), .acc_wr_in(acc_wr_in), .status_wr_in(status_wr_in),
      .mul_start_in(mul_start_in), .data_out(data_out), .ext_out(ext_out),
      .data_memory_address_out(data_memory_address_out), .mul_hi_out(mul_hi_out),
      .status_Z_out(status_Z_out), .status_N_out(status_N_out),
      .status_C_out(status_C_out), .status_V_out(status_V_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2*W+3:0] model_vec();
      return {m_acc, m_hi, m_z, m_n, m_c, m_v};
   endfunction

   function automatic logic [W-1:0] ext_ref(input longint o);
      if (o >= 1024) return W'(o + 65536 - 2048);
      return W'(o);
   endfunction

   // returns {result, Z, N, C, V}
   function automatic logic [W+3:0] alu_ref(input int op, input longint a, input longint b);
      longint sa, sb, s, t, r, p2;
      logic c, v;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      p2 = longint'(1) << (b % 16);
      c = 1'b0;
      v = 1'b0;
      case (op)
         0: begin s = a + b; r = s % 65536; c = (s > 65535); t = sa + sb; v = (t > 32767) || (t < -32768); end
         1: begin s = a - b; r = (s + 65536) % 65536; c = (a < b); t = sa - sb; v = (t > 32767) || (t < -32768); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 65535 - a;
         6: r = (a * p2) % 65536;
         default: r = a / p2;
      endcase
      return {W'(r), (r == 0), (r >= 32768), c, v};
   endfunction

   // drive one non-multiply cycle and advance the model
   task automatic idle_op(input int op, input int sela, input logic selb, input logic [W-1:0] mem,
                          input logic [OW-1:0] opnd, input logic accwr, input logic statwr);
      logic [W-1:0] b, src;
      logic [W+3:0] res;
      alu_op_in = 3'(op); sel_A_in = 2'(sela); sel_B_in = selb; data_memory_in = mem;
      operand_in = opnd; acc_wr_in = accwr; status_wr_in = statwr; mul_start_in = 1'b0;
      b = selb ? ext_ref(longint'(opnd)) : mem;
      res = alu_ref(op, longint'(m_acc), longint'(b));
      case (sela)
         0: src = mem;
         1: src = ext_ref(longint'(opnd));
         2: src = res[W+3:4];
         default: src = m_hi;
      endcase
      tick();
      acc_wr_in = 1'b0; status_wr_in = 1'b0;
      if (statwr) {m_z, m_n, m_c, m_v} = res[3:0];
      if (accwr) m_acc = src;
   endtask

   task automatic load_acc(input logic [W-1:0] val);
      idle_op(0, 0, 1'b0, val, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      reset_in = 1'b1; acc_wr_in = 1'b1; status_wr_in = 1'b1; mul_start_in = 1'b1;
      sel_A_in = 2'b00; data_memory_in = 16'hBEEF;
      tick(); tick();
      acc_wr_in = 1'b0; status_wr_in = 1'b0; mul_start_in = 1'b0;
      m_acc = '0; m_hi = '0; {m_z, m_n, m_c, m_v} = 4'b0;
      checks++;
      if (obs_vec !== model_vec() || busy_out !== 1'b0 || done_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: got %h busy=%b done=%b required %h busy=0 done=0", obs_vec, busy_out, done_out, model_vec());
      end
      reset_in = 1'b0;
      tick();
   endtask

   task automatic test_ext();
      logic [OW-1:0] o;
      for (int i = 0; i < 12; i++) begin
         o = (i == 0) ? 11'h400 : (i == 1) ? 11'h3FF : OW'($urandom);
         operand_in = o;
         #1;
         checks++;
         if (ext_out !== ext_ref(longint'(o)) || data_memory_address_out !== o) begin
            errors++;
            $display("FAIL ext[%0d]: operand %h got ext=%h addr=%h required ext=%h addr=%h",
                     i, o, ext_out, data_memory_address_out, ext_ref(longint'(o)), o);
         end
      end
   endtask

   task automatic test_alu_directed();
      idle_op(0, 1, 1'b0, '0, 11'h7FF, 1'b1, 1'b0);
      checks++;
      if (data_out !== 16'hFFFF) begin
         errors++; $display("FAIL load_ext: got %h required ffff", data_out);
      end
      idle_op(0, 0, 1'b0, 16'h0001, '0, 1'b0, 1'b1);
      checks++;
      if (obs_vec !== {16'hFFFF, 16'h0000, 4'b1010}) begin
         errors++; $display("FAIL add_carry: got %h required %h", obs_vec, {16'hFFFF, 16'h0000, 4'b1010});
      end
      load_acc(16'h8000);
      idle_op(1, 2, 1'b0, 16'h0001, '0, 1'b1, 1'b1);
      checks++;
      if (obs_vec !== {16'h7FFF, 16'h0000, 4'b0001}) begin
         errors++; $display("FAIL sub_ovf: got %h required %h", obs_vec, {16'h7FFF, 16'h0000, 4'b0001});
      end
   endtask

   task automatic test_alu_random();
      for (int i = 0; i < 60; i++) begin
         load_acc(W'($urandom));
         idle_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'($urandom), W'($urandom),
                 OW'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
         checks++;
         if (obs_vec !== model_vec()) begin
            errors++; $display("FAIL alu_rand[%0d]: got %h required %h", i, obs_vec, model_vec());
         end
      end
   endtask

   // start a multiply, follow the handshake and check the result
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      load_acc(a);
      sel_B_in = 1'b0; data_memory_in = b; mul_start_in = 1'b1;
      tick();
      mul_start_in = 1'b0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (busy_out !== 1'b1 || done_out !== 1'b0 || obs_vec !== model_vec()) begin
            errors++;
            $display("FAIL mul_busy[%0d] %h*%h: busy=%b done=%b state=%h required busy=1 done=0 state=%h",
                     i, a, b, busy_out, done_out, obs_vec, model_vec());
         end
         tick();
      end
      p = longint'(a) * longint'(b);
      m_acc = W'(p % 65536); m_hi = W'(p / 65536);
      m_z = (p == 0); m_n = (m_hi >= 16'h8000); m_c = (m_hi != 0); m_v = (m_hi != 0);
      checks++;
      if (done_out !== 1'b1 || busy_out !== 1'b0 || obs_vec !== model_vec()) begin
         errors++;
         $display("FAIL mul_done %h*%h: done=%b busy=%b result=%h required done=1 busy=0 result=%h",
                  a, b, done_out, busy_out, obs_vec, model_vec());
      end
      tick();
      checks++;
      if (done_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++; $display("FAIL mul_idle %h*%h: done=%b busy=%b required 0 0", a, b, done_out, busy_out);
      end
   endtask

   task automatic test_mul_directed();
      run_mul(16'h1234, 16'h0100);
      checks++;
      if (obs_vec !== {16'h3400, 16'h0012, 4'b0011}) begin
         errors++; $display("FAIL mul_1234: got %h required %h", obs_vec, {16'h3400, 16'h0012, 4'b0011});
      end
      idle_op(0, 3, 1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (data_out !== 16'h0012) begin
         errors++; $display("FAIL acc_from_hi: got %h required 0012", data_out);
      end
      run_mul(16'hFFFF, 16'hFFFF);
      checks++;
      if (obs_vec !== {16'h0001, 16'hFFFE, 4'b0111}) begin
         errors++; $display("FAIL mul_ffff: got %h required %h", obs_vec, {16'h0001, 16'hFFFE, 4'b0111});
      end
      run_mul(16'h0000, W'($urandom));
      checks++;
      if (obs_vec !== {16'h0000, 16'h0000, 4'b1000}) begin
         errors++; $display("FAIL mul_zero: got %h required %h", obs_vec, {16'h0000, 16'h0000, 4'b1000});
      end
   endtask

   task automatic test_mul_random();
      for (int i = 0; i < 8; i++) run_mul(W'($urandom), W'($urandom));
   endtask

   task automatic test_reset_abort();
      bit seen;
      load_acc(16'h1235);
      sel_B_in = 1'b0; data_memory_in = 16'h0777; mul_start_in = 1'b1;
      tick();
      mul_start_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (busy_out !== 1'b1) begin
         errors++; $display("FAIL abort_busy5: busy=%b required 1", busy_out);
      end
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      m_acc = '0; m_hi = '0; {m_z, m_n, m_c, m_v} = 4'b0;
      checks++;
      if (busy_out !== 1'b0 || done_out !== 1'b0 || obs_vec !== model_vec()) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b state=%h required 0 0 %h", busy_out, done_out, obs_vec, model_vec());
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (done_out === 1'b1) seen = 1;
         tick();
      end
      checks++;
      if (seen || obs_vec !== model_vec()) begin
         errors++; $display("FAIL abort_no_done: done_seen=%0d state=%h required 0 %h", seen, obs_vec, model_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a0, b2;
      longint p;
      a0 = W'($urandom) | 16'h0001;
      load_acc(a0);
      // start together with an ACC write: multiply must use the old ACC
      sel_A_in = 2'b00; sel_B_in = 1'b0; data_memory_in = 16'h00AA; acc_wr_in = 1'b1; mul_start_in = 1'b1;
      tick();
      acc_wr_in = 1'b0; mul_start_in = 1'b0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (busy_out !== 1'b1 || obs_vec !== model_vec()) begin
            errors++;
            $display("FAIL b2b_hold[%0d]: busy=%b state=%h required busy=1 state=%h", i, busy_out, obs_vec, model_vec());
         end
         acc_wr_in = 1'b1; status_wr_in = 1'b1; mul_start_in = 1'(i % 2);
         sel_A_in = 2'($urandom); data_memory_in = W'($urandom); alu_op_in = 3'($urandom);
         tick();
      end
      acc_wr_in = 1'b0; status_wr_in = 1'b0; mul_start_in = 1'b0;
      p = longint'(a0) * 170;
      m_acc = W'(p % 65536); m_hi = W'(p / 65536);
      m_z = (p == 0); m_n = (m_hi >= 16'h8000); m_c = (m_hi != 0); m_v = (m_hi != 0);
      checks++;
      if (done_out !== 1'b1 || obs_vec !== model_vec()) begin
         errors++; $display("FAIL b2b_done1: done=%b result=%h required 1 %h", done_out, obs_vec, model_vec());
      end
      // restart in the DONE cycle
      b2 = W'($urandom);
      sel_B_in = 1'b0; data_memory_in = b2; mul_start_in = 1'b1;
      tick();
      mul_start_in = 1'b0;
      checks++;
      if (busy_out !== 1'b1 || done_out !== 1'b0) begin
         errors++; $display("FAIL b2b_nogap: busy=%b done=%b required 1 0", busy_out, done_out);
      end
      for (int i = 0; i < W - 1; i++) tick();
      checks++;
      if (busy_out !== 1'b1) begin
         errors++; $display("FAIL b2b_busy16: busy=%b required 1", busy_out);
      end
      tick();
      p = longint'(m_acc) * longint'(b2);
      m_acc = W'(p % 65536); m_hi = W'(p / 65536);
      m_z = (p == 0); m_n = (m_hi >= 16'h8000); m_c = (m_hi != 0); m_v = (m_hi != 0);
      checks++;
      if (done_out !== 1'b1 || busy_out !== 1'b0 || obs_vec !== model_vec()) begin
         errors++; $display("FAIL b2b_done2: done=%b busy=%b result=%h required 1 0 %h", done_out, busy_out, obs_vec, model_vec());
      end
      tick();
   endtask

   initial begin
      reset_in = 1'b1; operand_in = '0; data_memory_in = '0; alu_op_in = '0; sel_A_in = '0;
      sel_B_in = 1'b0; acc_wr_in = 1'b0; status_wr_in = 1'b0; mul_start_in = 1'b0;
      test_reset();
      test_ext();
      test_alu_directed();
      test_alu_random();
      test_mul_directed();
      test_mul_random();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
